// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use hazard detection, redirect flush and a
// saturating stall-event counter for debug visibility.
module if_id_stage #(
    parameter int ADDR_W  = 30,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_in,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               flush,
    input  logic               ex_mem_read,
    input  logic [4:0]         ex_rt,
    output logic [ADDR_W-1:0]  pc_out,
    output logic [ADDR_W-1:0]  pc_plus1_out,
    output logic [INSTR_W-1:0] instr_out,
    output logic               valid_out,
    output logic               pc_hold,
    output logic               bubble,
    output logic [CNT_W-1:0]   stall_count
);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_SW    = 6'd43;

    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic               r_valid;
    logic [CNT_W-1:0]   r_cnt;

    logic [5:0] w_op;
    logic [4:0] w_rs;
    logic [4:0] w_rt;
    logic       w_uses_rt;
    logic       w_hazard;

    assign w_op = r_instr[31:26];
    assign w_rs = r_instr[25:21];
    assign w_rt = r_instr[20:16];

    // Only R-type, beq, bne and sw read rt as a source; loads write it.
    assign w_uses_rt = (w_op == OP_RTYPE) | (w_op == OP_BEQ) |
                       (w_op == OP_BNE)   | (w_op == OP_SW);

    assign w_hazard = r_valid & ex_mem_read & (ex_rt != 5'd0) &
                      ((ex_rt == w_rs) | (w_uses_rt & (ex_rt == w_rt)));

    assign pc_hold = ~reset & w_hazard & ~flush;
    assign bubble  = ~reset & (w_hazard | flush);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= '0;
            r_instr <= '0;
            r_valid <= 1'b0;
            r_cnt   <= '0;
        end else if (flush) begin
            r_pc    <= pc_in;
            r_instr <= '0;
            r_valid <= 1'b0;
        end else if (w_hazard) begin
            if (r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_pc    <= pc_in;
            r_instr <= instr_in;
            r_valid <= 1'b1;
        end
    end

    assign pc_out       = r_pc;
    assign pc_plus1_out = r_pc + 1'b1;
    assign instr_out    = r_instr;
    assign valid_out    = r_valid;
    assign stall_count  = r_cnt;

endmodule

// File: tb/tb_if_id_stage.sv
// Scoreboard bench for if_id_stage: the driver queues the outputs expected in
// each cycle, a negedge monitor pops and compares them.
module tb_if_id_stage;

    localparam int ADDR_W  = 30;
    localparam int INSTR_W = 32;
    localparam int CNT_W   = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [ADDR_W-1:0]  pc_in = '0;
    logic [INSTR_W-1:0] instr_in = '0;
    logic               flush = 1'b0;
    logic               ex_mem_read = 1'b0;
    logic [4:0]         ex_rt = '0;
    logic [ADDR_W-1:0]  pc_out;
    logic [ADDR_W-1:0]  pc_plus1_out;
    logic [INSTR_W-1:0] instr_out;
    logic               valid_out;
    logic               pc_hold;
    logic               bubble;
    logic [CNT_W-1:0]   stall_count;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic              hold;
        logic              bub;
        logic              chk_regs;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] pc1;
        logic [31:0]       instr;
        logic              valid;
        logic [CNT_W-1:0]  cnt;
    } exp_t;

    exp_t exp_q[$];

    if_id_stage #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_in        (pc_in),
        .instr_in     (instr_in),
        .flush        (flush),
        .ex_mem_read  (ex_mem_read),
        .ex_rt        (ex_rt),
        .pc_out       (pc_out),
        .pc_plus1_out (pc_plus1_out),
        .instr_out    (instr_out),
        .valid_out    (valid_out),
        .pc_hold      (pc_hold),
        .bubble       (bubble),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int cyc,
                         input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s (vector %0d): got 0x%08h, expected 0x%08h", name, cyc, act, req);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected during it.
    task automatic vec(input logic rst, input logic fl, input logic exr,
                       input logic [4:0] ert, input logic [ADDR_W-1:0] pc,
                       input logic [31:0] ins, input logic eh, input logic eb,
                       input logic chk, input logic [ADDR_W-1:0] epc,
                       input logic [ADDR_W-1:0] epc1, input logic [31:0] ei,
                       input logic ev, input logic [CNT_W-1:0] ec);
        exp_t e;
        @(posedge clk);
        #1;
        reset       = rst;
        flush       = fl;
        ex_mem_read = exr;
        ex_rt       = ert;
        pc_in       = pc;
        instr_in    = ins;
        e.hold = eh; e.bub = eb; e.chk_regs = chk;
        e.pc = epc; e.pc1 = epc1; e.instr = ei; e.valid = ev; e.cnt = ec;
        exp_q.push_back(e);
    endtask

    int vec_idx = 0;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("pc_hold", vec_idx, 32'(pc_hold), 32'(e.hold));
            check("bubble",  vec_idx, 32'(bubble),  32'(e.bub));
            if (e.chk_regs) begin
                check("pc_out",       vec_idx, 32'(pc_out),       32'(e.pc));
                check("pc_plus1_out", vec_idx, 32'(pc_plus1_out), 32'(e.pc1));
                check("instr_out",    vec_idx, instr_out,         e.instr);
                check("valid_out",    vec_idx, 32'(valid_out),    32'(e.valid));
                check("stall_count",  vec_idx, 32'(stall_count),  32'(e.cnt));
            end
            vec_idx++;
        end
    end

    initial begin
        //  rst fl exr ert  pc_in     instr_in       hold bub chk pc_out    pc+1      instr_out     v  cnt
        vec(1, 0, 0, 0, 30'h000, 32'h0000_0000, 0, 0, 0, 30'h000, 30'h001, 32'h0000_0000, 0, 0);
        vec(1, 0, 0, 0, 30'h000, 32'h0000_0000, 0, 0, 1, 30'h000, 30'h001, 32'h0000_0000, 0, 0);
        // Stream three words after reset.
        vec(0, 0, 0, 0, 30'h100, 32'h8C22_0000, 0, 0, 1, 30'h000, 30'h001, 32'h0000_0000, 0, 0);
        vec(0, 0, 0, 0, 30'h101, 32'h0000_0000, 0, 0, 1, 30'h100, 30'h101, 32'h8C22_0000, 1, 0);
        vec(0, 0, 0, 0, 30'h102, 32'h012A_4020, 0, 0, 1, 30'h101, 30'h102, 32'h0000_0000, 1, 0);
        vec(0, 0, 0, 0, 30'h103, 32'h0043_4020, 0, 0, 1, 30'h102, 30'h103, 32'h012A_4020, 1, 0);
        // Load-use on rs: add $8,$2,$3 behind a load to $2.
        vec(0, 0, 1, 2, 30'h104, 32'h014B_6020, 1, 1, 1, 30'h103, 30'h104, 32'h0043_4020, 1, 0);
        vec(0, 0, 0, 0, 30'h104, 32'h014B_6020, 0, 0, 1, 30'h103, 30'h104, 32'h0043_4020, 1, 1);
        vec(0, 0, 0, 0, 30'h105, 32'hAC85_0000, 0, 0, 1, 30'h104, 30'h105, 32'h014B_6020, 1, 1);
        // sw $5 depends on rt.
        vec(0, 0, 1, 5, 30'h106, 32'h8C85_0000, 1, 1, 1, 30'h105, 30'h106, 32'hAC85_0000, 1, 1);
        vec(0, 0, 0, 0, 30'h106, 32'h8C85_0000, 0, 0, 1, 30'h105, 30'h106, 32'hAC85_0000, 1, 2);
        // lw $5 does not read rt: no stall.
        vec(0, 0, 1, 5, 30'h107, 32'h0000_0000, 0, 0, 1, 30'h106, 30'h107, 32'h8C85_0000, 1, 2);
        // Load to $0 with matching fields: no stall.
        vec(0, 0, 1, 0, 30'h108, 32'h0043_4020, 0, 0, 1, 30'h107, 30'h108, 32'h0000_0000, 1, 2);
        // Flush coincides with a hazard.
        vec(0, 1, 1, 2, 30'h200, 32'h1234_5678, 0, 1, 1, 30'h108, 30'h109, 32'h0043_4020, 1, 2);
        // Flush alone.
        vec(0, 1, 0, 0, 30'h201, 32'h0043_4020, 0, 1, 1, 30'h200, 30'h201, 32'h0000_0000, 0, 2);
        vec(0, 0, 0, 0, 30'h202, 32'h0043_4020, 0, 0, 1, 30'h201, 30'h202, 32'h0000_0000, 0, 2);
        // Twenty stalled cycles drive the 4-bit counter into saturation.
        for (int k = 0; k < 20; k++) begin
            vec(0, 0, 1, 2, 30'h203, 32'h0000_0000, 1, 1, 1, 30'h202, 30'h203, 32'h0043_4020, 1,
                (k + 2 > 15) ? 4'd15 : 4'(k + 2));
        end
        // Reset while the hazard is still asserted.
        vec(1, 0, 1, 2, 30'h203, 32'h0000_0000, 0, 0, 1, 30'h202, 30'h203, 32'h0043_4020, 1, 15);
        vec(1, 0, 1, 2, 30'h203, 32'h0000_0000, 0, 0, 1, 30'h000, 30'h001, 32'h0000_0000, 0, 0);
        // Word address wrap-around of pc_plus1_out.
        vec(0, 0, 0, 0, 30'h3FFF_FFFF, 32'h0000_0000, 0, 0, 1, 30'h000, 30'h001, 32'h0000_0000, 0, 0);
        vec(0, 0, 0, 0, 30'h000, 32'h0000_0000, 0, 0, 1, 30'h3FFF_FFFF, 30'h000, 32'h0000_0000, 1, 0);
        vec(0, 0, 0, 0, 30'h001, 32'h0000_0000, 0, 0, 1, 30'h000, 30'h001, 32'h0000_0000, 1, 0);

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
